// File: rtl/oflow_core_fsm_fe_param.sv
// oflow_core_fsm_fe_param: steps a frame set by set, starting the active PEs and
// gathering their done pulses before handing each set over to registration.
module oflow_core_fsm_fe_param #(
  parameter int PE_NUM = 24,
  parameter int SET_LEN = 11,
  parameter int REMAIN_LEN = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SET_LEN-1:0]    num_of_sets,
  input  logic                  start_pe,
  input  logic [REMAIN_LEN-1:0] counter_of_remain_bboxes,
  input  logic                  new_set,
  input  logic                  abort,
  input  logic                  done_registration,
  input  logic [PE_NUM-1:0]     done_fe_i,
  output logic [PE_NUM-1:0]     start_fe_i,
  output logic                  done_fe,
  output logic [SET_LEN-1:0]    counter_set_fe,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, DISPATCH = 2'd1, WAIT_FE = 2'd2, WAIT_REG = 2'd3;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PE_NUM-1:0] ONES = '1;
  logic [1:0] state_q, state_d;
  logic [SET_LEN-1:0] nsets_q, nsets_d, cnt_q, cnt_d;
  logic [PE_NUM-1:0] mask_q, mask_d, sticky_q, sticky_d, start_q, start_d, mask_c, hit;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic reg_seen_q, reg_seen_d, done_q, done_d, fdone_q, fdone_d, busy_q, terr_q, terr_d;
  logic last, complete, expire, proceed;
  int unsigned r;

  always_comb begin
    last = cnt_q == nsets_q - SET_LEN'(1);
    r = 32'(counter_of_remain_bboxes);
    // a partial last set starts only its low R PEs; R of 0 or beyond PE_NUM means a full set
    mask_c = (last && r != 0 && r < PE_NUM) ? ONES >> (PE_NUM - r) : ONES;
    hit = sticky_q | (done_fe_i & mask_q);
    complete = hit == mask_q;
    expire = TIMEOUT_CYC != 0 && tcnt_q == TW'(TIMEOUT_CYC - 1);
    proceed = cnt_q == '0 || reg_seen_q || done_registration;
    state_d = state_q;
    nsets_d = nsets_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    sticky_d = sticky_q;
    tcnt_d = tcnt_q;
    terr_d = terr_q;
    start_d = '0;
    done_d = 1'b0;
    fdone_d = 1'b0;
    case (state_q)
      IDLE: if (start_pe) begin
        nsets_d = num_of_sets;
        cnt_d = '0;
        terr_d = 1'b0;
        fdone_d = num_of_sets == '0;
        state_d = num_of_sets == '0 ? IDLE : DISPATCH;
      end
      DISPATCH: if (new_set) begin
        start_d = mask_c;
        mask_d = mask_c;
        sticky_d = '0;
        tcnt_d = '0;
        state_d = WAIT_FE;
      end
      WAIT_FE: begin
        sticky_d = hit;
        done_d = complete;
        terr_d = terr_q | (!complete && expire);
        tcnt_d = tcnt_q + TW'(1);
        state_d = complete ? WAIT_REG : expire ? IDLE : WAIT_FE;
      end
      default: if (proceed) begin
        fdone_d = last;
        cnt_d = last ? cnt_q : cnt_q + SET_LEN'(1);
        state_d = last ? IDLE : DISPATCH;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
      terr_d = terr_q;
      start_d = '0;
      done_d = 1'b0;
      fdone_d = 1'b0;
    end
    reg_seen_d = (state_d == IDLE || (state_q == WAIT_REG && state_d != WAIT_REG)) ? 1'b0
               : reg_seen_q | (state_q != IDLE && done_registration);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nsets_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      sticky_q <= '0;
      start_q <= '0;
      tcnt_q <= '0;
      reg_seen_q <= 1'b0;
      done_q <= 1'b0;
      fdone_q <= 1'b0;
      busy_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nsets_q <= nsets_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      sticky_q <= sticky_d;
      start_q <= start_d;
      tcnt_q <= tcnt_d;
      reg_seen_q <= reg_seen_d;
      done_q <= done_d;
      fdone_q <= fdone_d;
      busy_q <= state_d != IDLE;
      terr_q <= terr_d;
    end
  end

  assign start_fe_i = start_q;
  assign done_fe = done_q;
  assign counter_set_fe = cnt_q;
  assign frame_done = fdone_q;
  assign busy = busy_q;
  assign timeout_err = terr_q;
endmodule

// File: doc/oflow_core_fsm_fe_param.md
OFLOW_CORE_FSM_FE_PARAM -- requirements
Module: oflow_core_fsm_fe_param

Interface
REQ-001 Parameter PE_NUM, 24, number of feature-extraction PEs driven by the block.
REQ-002 Parameter SET_LEN, 11, width of set count and set index.
REQ-003 Parameter REMAIN_LEN, 5, width of the remaining-bbox count; SHALL satisfy 2^REMAIN_LEN > PE_NUM.
REQ-004 Parameter TIMEOUT_CYC, 1024, WAIT_FE cycle limit; 0 disables the timeout.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 num_of_sets  input  SET_LEN  sets in frame; sampled on frame start.
REQ-009 start_pe  input  1  frame start request.
REQ-010 counter_of_remain_bboxes  input  REMAIN_LEN  bboxes in the last set.
REQ-011 new_set  input  1  next set is loaded and ready for dispatch.
REQ-012 abort  input  1  terminates the frame.
REQ-013 done_registration  input  1  registration of the previous set is complete (pulse).
REQ-014 done_fe_i  input  PE_NUM  per-PE done pulses.
REQ-015 start_fe_i  output  PE_NUM  per-PE start pulses.
REQ-016 done_fe  output  1  all active PEs are done for the current set (pulse).
REQ-017 counter_set_fe  output  SET_LEN  index of the set in flight.
REQ-018 frame_done  output  1  frame complete (pulse).
REQ-019 busy  output  1  high when state is not IDLE.
REQ-020 timeout_err  output  1  sticky timeout flag.

Function
REQ-021 States SHALL be IDLE, DISPATCH, WAIT_FE and WAIT_REG; all outputs SHALL be registered.
REQ-022 IDLE: start_pe with num_of_sets != 0 -> latch num_of_sets, clear timeout_err, counter_set_fe = 0, go to DISPATCH.
REQ-023 IDLE: start_pe with num_of_sets == 0 -> pulse frame_done for 1 cycle, clear timeout_err, stay in IDLE.
REQ-024 start_pe SHALL be ignored outside IDLE; num_of_sets changes mid-frame SHALL be ignored.
REQ-025 DISPATCH: on new_set=1, drive start_fe_i = active mask for exactly 1 cycle (the cycle after new_set is sampled), clear the sticky done vector, go to WAIT_FE; otherwise wait in DISPATCH.
REQ-026 Active mask = all ones, except on the last set (counter_set_fe == latched num_of_sets-1), where it is the low R bits with R = counter_of_remain_bboxes.
REQ-027 On the last set, R == 0 or R >= PE_NUM SHALL give an all-ones mask.
REQ-028 WAIT_FE: sticky vector |= done_fe_i & mask; done bits outside the mask SHALL be ignored.
REQ-029 PE done pulses may arrive in any order or cycle; completion is reached when (sticky | (done_fe_i & mask)) == mask.
REQ-030 On completion: pulse done_fe for 1 cycle, go to WAIT_REG.
REQ-031 A sticky reg_seen flag SHALL set on done_registration in any non-IDLE state and clear whenever the FSM leaves WAIT_REG.
REQ-032 WAIT_REG proceeds when counter_set_fe == 0, or reg_seen is set, or done_registration is high in that cycle.
REQ-033 On proceeding: if the set was the last, pulse frame_done and go to IDLE; otherwise counter_set_fe += 1 and go to DISPATCH.
REQ-034 Timeout: WAIT_FE cycles are counted from 0 on entry; reaching TIMEOUT_CYC (when nonzero) -> set timeout_err, go to IDLE, no done_fe pulse.
REQ-035 abort SHALL have priority in every state: next state IDLE, counter_set_fe = 0, and start_fe_i, done_fe and frame_done held 0 that cycle.
REQ-036 counter_set_fe SHALL not wrap; the maximum index is latched num_of_sets-1.
REQ-037 If completion and timeout occur in the same cycle, completion SHALL win.

Reset
REQ-038 reset=1 at any edge -> state IDLE; start_fe_i, done_fe, frame_done, busy and timeout_err all 0; counter_set_fe 0; sticky vector, reg_seen and timeout counter cleared.
REQ-039 reset mid-frame SHALL discard all in-flight state; the first legal start_pe after reset releases starts a fresh frame.

Verification
REQ-040 PE_NUM=24, num_of_sets=3, remain=5, simultaneous dones, done_registration after each done_fe -> start_fe_i 0xFFFFFF, 0xFFFFFF, 0x00001F; counter_set_fe 0,1,2; three done_fe pulses; one frame_done pulse.
REQ-041 Staggered dones (one PE per cycle, 24 cycles), plus a stray done on bit 23 under mask 0x00001F -> done_fe exactly once, 1 cycle after the last in-mask bit; stray bit ignored.
REQ-042 TIMEOUT_CYC=16, PE 7 never done -> timeout_err=1 after 16 WAIT_FE cycles, busy=0, no done_fe; next start_pe clears timeout_err.
REQ-043 abort in WAIT_FE of set 1 -> next cycle busy=0, counter_set_fe=0, no done_fe or frame_done.
REQ-044 num_of_sets=0 -> frame_done pulse, start_fe_i stays 0; num_of_sets=1 with remain=0 -> start_fe_i=0xFFFFFF and frame_done after done_fe without waiting for done_registration.
REQ-045 reset asserted during WAIT_REG of set 2 -> all outputs 0 at the next edge; a new frame then runs cleanly from set 0.
